// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates one-hot column drive, debounces a single row hit,
// presents the key code until the consumer accepts it, then waits for release.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] keyRows,
  input  logic       keyReady,
  output logic [3:0] keyCols,
  output logic [4:0] Key,
  output logic       keyValid
);

  // state    | meaning
  // SCAN     | rotating columns, looking for exactly one active row
  // DEBOUNCE | column frozen, counting matching samples of the captured row
  // PRESSED  | key code presented, waiting for keyReady
  // RELEASE  | column frozen, counting all-zero row samples
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_TGT   = 4'(DEB_CNT);
  localparam logic [4:0] NO_KEY    = 5'd16;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_slot;
  logic [1:0] r_col, w_col_nxt;
  logic [1:0] r_row, w_row_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_rel, w_rel_nxt;
  logic       r_valid, w_valid_nxt;
  logic [4:0] r_key, w_key_nxt;

  logic       w_sample;
  logic       w_one_hot;
  logic [1:0] w_row_idx;
  logic [3:0] w_row_mask;

  assign w_sample   = (r_slot == SLOT_LAST);
  assign w_one_hot  = (keyRows != 4'd0) && ((keyRows & (keyRows - 4'd1)) == 4'd0);
  assign w_row_mask = 4'b0001 << r_row;

  always_comb begin
    w_row_idx = 2'd0;
    case (keyRows)
      4'b0010: w_row_idx = 2'd1;
      4'b0100: w_row_idx = 2'd2;
      4'b1000: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = r_rel;
    w_valid_nxt = r_valid;
    w_key_nxt   = r_key;
    case (r_state)
      SCAN: begin
        if (w_sample) begin
          if (w_one_hot) begin
            w_row_nxt = w_row_idx;
            w_cnt_nxt = 4'd1;
            if (DEB_TGT == 4'd1) begin
              w_state_nxt = PRESSED;
              w_valid_nxt = 1'b1;
              w_key_nxt   = {1'b0, r_col, w_row_idx};
            end else begin
              w_state_nxt = DEBOUNCE;
            end
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (w_sample) begin
          if (keyRows == w_row_mask) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt + 4'd1 == DEB_TGT) begin
              w_state_nxt = PRESSED;
              w_valid_nxt = 1'b1;
              w_key_nxt   = {1'b0, r_col, r_row};
            end
          end else begin
            w_state_nxt = SCAN;
            w_col_nxt   = r_col + 2'd1;
            w_cnt_nxt   = 4'd0;
          end
        end
      end
      PRESSED: begin
        // Row activity is ignored here; only the handshake moves us on.
        if (keyReady) begin
          w_state_nxt = RELEASE;
          w_valid_nxt = 1'b0;
          w_key_nxt   = NO_KEY;
          w_cnt_nxt   = 4'd0;
          w_rel_nxt   = 4'd0;
        end
      end
      RELEASE: begin
        if (w_sample) begin
          if (keyRows == 4'd0) begin
            if (r_rel + 4'd1 == DEB_TGT) begin
              w_state_nxt = SCAN;
              w_col_nxt   = r_col + 2'd1;
              w_rel_nxt   = 4'd0;
            end else begin
              w_rel_nxt = r_rel + 4'd1;
            end
          end else begin
            w_rel_nxt = 4'd0;
          end
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= SCAN;
      r_slot  <= 8'd0;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_cnt   <= 4'd0;
      r_rel   <= 4'd0;
      r_valid <= 1'b0;
      r_key   <= NO_KEY;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_sample ? 8'd0 : r_slot + 8'd1;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rel   <= w_rel_nxt;
      r_valid <= w_valid_nxt;
      r_key   <= w_key_nxt;
    end
  end

  assign keyCols  = 4'b0001 << r_col;
  assign Key      = r_key;
  assign keyValid = r_valid;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each column is driven before one row sample (legal 2..255).
REQ-002 SHALL have parameter DEB_CNT, default 3: consecutive equal row samples needed to accept a press or release (legal 1..15).
REQ-003 SHALL have port CLK  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port keyRows  input  4  keypad row sense, active-high, bit r = row r.
REQ-006 SHALL have port keyReady  input  1  consumer accepts Key on a cycle where keyValid is also high.
REQ-007 SHALL have port keyCols  output  4  column drive, one-hot, active-high, bit c = column c.
REQ-008 SHALL have port Key  output  5  key code; 0..15 = col*4+row; 5'd16 = no key.
REQ-009 SHALL have port keyValid  output  1  Key holds a debounced press awaiting acceptance.

Function
REQ-010 SHALL run a slot counter 0..SCAN_DIV-1; a row sample is taken on each edge where the counter equals SCAN_DIV-1, and the counter then wraps to 0.
REQ-011 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-012 SCAN: keyCols SHALL rotate 0001->0010->0100->1000->0001 on each sample edge that finds no valid key.
REQ-013 SCAN: a sample with exactly one keyRows bit set SHALL capture (column, row), set the match count to 1, freeze keyCols, and enter DEBOUNCE; DEB_CNT=1 enters PRESSED directly.
REQ-014 SCAN: a sample with two or more row bits set (ghosting) SHALL be treated as no key.
REQ-015 DEBOUNCE: each sample equal to the captured one-hot row SHALL increment the match count; on reaching DEB_CNT, the state SHALL go to PRESSED on that same edge.
REQ-016 DEBOUNCE: any mismatching sample SHALL return to SCAN with keyCols advanced to the next column.
REQ-017 PRESSED: keyValid=1 and Key=col*4+row SHALL be registered on the edge entering PRESSED and held stable until acceptance.
REQ-018 Acceptance SHALL occur on an edge with keyValid=1 and keyReady=1; keyValid drops to 0 and Key to 16 on that edge, and the state goes to RELEASE.
REQ-019 PRESSED without keyReady SHALL hold indefinitely; no other key is scanned and row activity is ignored.
REQ-020 keyReady while keyValid=0 SHALL have no effect.
REQ-021 RELEASE: keyCols SHALL stay frozen; DEB_CNT consecutive samples of keyRows=0000 SHALL return to SCAN with keyCols advanced to the next column; any nonzero sample clears the release count.
REQ-022 Key SHALL equal 5'd16 whenever keyValid=0.
REQ-023 keyCols SHALL always be exactly one-hot; at most one key is reported per press/release cycle.
REQ-024 Counters SHALL saturate or clear as specified and never wrap silently; the match count width is 4 bits and the slot counter width is 8 bits.

Reset
REQ-025 On any edge with RST=1: state=SCAN, keyCols=0001, slot count=0, match and release counts=0, keyValid=0, Key=16.
REQ-026 RST SHALL override all other inputs on the same edge, including an acceptance handshake.
REQ-027 RST asserted mid-DEBOUNCE, mid-PRESSED or mid-RELEASE SHALL drop keyValid and restart scanning from column 0; no partial key is emitted.

Verification
REQ-028 Defaults; keyRows=0001 held from reset release, keyReady=0 -> keyValid=1, Key=0 after the 12th edge; stays high and stable for 100 cycles.
REQ-029 Continuing REQ-028: keyReady=1 for one cycle -> keyValid=0, Key=16 next edge; rows held -> no new keyValid; rows=0000 for 3 samples -> keyCols=0010 after the 3rd sample edge.
REQ-030 Defaults; rows=0100 only while keyCols=0100, other rows 0 -> Key=10 after 3 matching samples in column 2; keyCols stays 0100 through PRESSED/RELEASE.
REQ-031 Bounce: rows=0001 for 1 sample then 0000 -> returns to SCAN, keyCols=0010, keyValid never asserts; rows=1010 in any column -> no capture.
REQ-032 RST=1 for one cycle while keyValid=1 and keyReady=1 -> next edge keyValid=0, Key=16, keyCols=0001, slot count=0.
REQ-033 SCAN_DIV=2, DEB_CNT=1, rows=1000 in column 3 -> keyValid=1, Key=15 on the first column-3 sample edge (edge 8 after reset).
